// File: rtl/router_fifo.sv
// router_fifo: per-port router output FIFO with header tagging and packet-length tracked data_out release
module router_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             soft_reset,
   input  logic             write_enb,
   input  logic             read_enb,
   input  logic             lfd_state,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out,
   output logic             full,
   output logic             empty
);
   logic [WIDTH:0]   mem [DEPTH];
   logic [AW:0]      wr_ptr, rd_ptr;
   logic [5:0]       pkt_cnt;
   logic [WIDTH-1:0] dq;
   logic             hiz;
   logic             wr, rd;
   logic [WIDTH:0]   rword;
   assign empty    = wr_ptr == rd_ptr;
   assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign wr       = write_enb && !full;
   assign rd       = read_enb && !empty;
   assign rword    = mem[rd_ptr[AW-1:0]];
   assign data_out = hiz ? 'z : dq;
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         pkt_cnt <= '0;
         dq      <= '0;
         hiz     <= 1'b0;
      end else if (soft_reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         pkt_cnt <= '0;
         hiz     <= 1'b1;
      end else begin
         if (wr) begin
            mem[wr_ptr[AW-1:0]] <= {lfd_state, data_in};
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd) begin
            dq      <= rword[WIDTH-1:0];
            hiz     <= 1'b0;
            rd_ptr  <= rd_ptr + 1'b1;
            // header carries payload length in bits 7:2; +1 accounts for the parity byte
            pkt_cnt <= rword[WIDTH] ? rword[7:2] + 6'd1 : pkt_cnt - {5'd0, pkt_cnt != 6'd0};
         end else if (pkt_cnt == 6'd0) begin
            hiz <= 1'b1;
         end
      end
endmodule

// File: tb/tb_router_fifo.sv
// tb_router_fifo: directed self-checking bench for router_fifo
module tb_router_fifo;
   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       soft_reset = 1'b0;
   logic       write_enb = 1'b0;
   logic       read_enb = 1'b0;
   logic       lfd_state = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic [7:0] data_out;
   logic       full, empty;
   logic [7:0] zz;
   int         checks = 0;
   int         passed = 0;

   router_fifo dut (
      .clk(clk), .resetn(resetn), .soft_reset(soft_reset), .write_enb(write_enb),
      .read_enb(read_enb), .lfd_state(lfd_state), .data_in(data_in),
      .data_out(data_out), .full(full), .empty(empty)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_byte(input logic lfd, input logic [7:0] d);
      write_enb = 1'b1;
      lfd_state = lfd;
      data_in   = d;
      tick();
      write_enb = 1'b0;
      lfd_state = 1'b0;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      write_enb = 1'b1;
      read_enb = 1'b1;
      data_in = 8'hAB;
      repeat (3) tick();
      checks++; if (data_out !== 8'h00) $display("FAIL reset_data got %h exp 00", data_out); else passed++;
      checks++; if (empty !== 1'b1) $display("FAIL reset_empty got %b exp 1", empty); else passed++;
      checks++; if (full !== 1'b0) $display("FAIL reset_full got %b exp 0", full); else passed++;
      @(negedge clk);
      resetn = 1'b1;
      write_enb = 1'b0;
      read_enb = 1'b0;
      tick();
      checks++; if (empty !== 1'b1) $display("FAIL release_empty got %b exp 1", empty); else passed++;
      checks++; if (full !== 1'b0) $display("FAIL release_full got %b exp 0", full); else passed++;
   endtask

   task automatic test_fill();
      for (int i = 1; i <= 16; i++) wr_byte(1'b0, 8'(i));
      checks++; if (full !== 1'b1) $display("FAIL fill_full got %b exp 1", full); else passed++;
      checks++; if (empty !== 1'b0) $display("FAIL fill_empty got %b exp 0", empty); else passed++;
      wr_byte(1'b0, 8'hFF);
      checks++; if (full !== 1'b1) $display("FAIL overflow_full got %b exp 1", full); else passed++;
      read_enb = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         tick();
         checks++; if (data_out !== 8'(i)) $display("FAIL fill_read%0d got %h exp %h", i, data_out, 8'(i)); else passed++;
      end
      read_enb = 1'b0;
      checks++; if (empty !== 1'b1) $display("FAIL drain_empty got %b exp 1", empty); else passed++;
      checks++; if (full !== 1'b0) $display("FAIL drain_full got %b exp 0", full); else passed++;
      tick();
      checks++; if (data_out !== zz) $display("FAIL fill_release got %h exp zz", data_out); else passed++;
   endtask

   task automatic test_packet();
      logic [7:0] exp [5];
      exp = '{8'h0D, 8'hAA, 8'hBB, 8'hCC, 8'h5E};
      wr_byte(1'b1, 8'h0D);
      for (int i = 1; i < 5; i++) wr_byte(1'b0, exp[i]);
      read_enb = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++; if (data_out !== exp[i]) $display("FAIL pkt_byte%0d got %h exp %h", i, data_out, exp[i]); else passed++;
      end
      read_enb = 1'b0;
      tick();
      checks++; if (data_out !== zz) $display("FAIL pkt_release got %h exp zz", data_out); else passed++;
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 16; i++) wr_byte(1'b0, 8'h20 + 8'(i));
      write_enb = 1'b1;
      read_enb = 1'b1;
      data_in = 8'h99;
      tick();
      write_enb = 1'b0;
      checks++; if (data_out !== 8'h20) $display("FAIL full_rw_data got %h exp 20", data_out); else passed++;
      checks++; if (full !== 1'b0) $display("FAIL full_rw_full got %b exp 0", full); else passed++;
      for (int i = 1; i < 16; i++) begin
         tick();
         checks++; if (data_out !== 8'h20 + 8'(i)) $display("FAIL full_rw_read%0d got %h exp %h", i, data_out, 8'h20 + 8'(i)); else passed++;
      end
      checks++; if (empty !== 1'b1) $display("FAIL full_rw_dropped got empty=%b exp 1", empty); else passed++;
      write_enb = 1'b1;
      data_in = 8'h77;
      tick();
      write_enb = 1'b0;
      checks++; if (empty !== 1'b0) $display("FAIL empty_rw_empty got %b exp 0", empty); else passed++;
      checks++; if (data_out !== zz) $display("FAIL empty_rw_ignored got %h exp zz", data_out); else passed++;
      tick();
      checks++; if (data_out !== 8'h77) $display("FAIL empty_rw_data got %h exp 77", data_out); else passed++;
      read_enb = 1'b0;
      wr_byte(1'b0, 8'h11);
      write_enb = 1'b1;
      read_enb = 1'b1;
      data_in = 8'h22;
      tick();
      write_enb = 1'b0;
      checks++; if (data_out !== 8'h11) $display("FAIL mid_rw_data got %h exp 11", data_out); else passed++;
      checks++; if (empty !== 1'b0) $display("FAIL mid_rw_empty got %b exp 0", empty); else passed++;
      tick();
      read_enb = 1'b0;
      checks++; if (data_out !== 8'h22) $display("FAIL mid_rw_second got %h exp 22", data_out); else passed++;
      checks++; if (empty !== 1'b1) $display("FAIL mid_rw_final_empty got %b exp 1", empty); else passed++;
      tick();
   endtask

   task automatic test_soft_reset();
      wr_byte(1'b1, 8'h0D);
      wr_byte(1'b0, 8'hAA);
      wr_byte(1'b0, 8'hBB);
      wr_byte(1'b0, 8'hCC);
      wr_byte(1'b0, 8'h5E);
      read_enb = 1'b1;
      repeat (2) tick();
      read_enb = 1'b0;
      tick();
      checks++; if (data_out !== 8'hAA) $display("FAIL soft_hold got %h exp aa", data_out); else passed++;
      soft_reset = 1'b1;
      write_enb = 1'b1;
      data_in = 8'h55;
      tick();
      soft_reset = 1'b0;
      write_enb = 1'b0;
      checks++; if (empty !== 1'b1) $display("FAIL soft_empty got %b exp 1", empty); else passed++;
      checks++; if (data_out !== zz) $display("FAIL soft_release got %h exp zz", data_out); else passed++;
      read_enb = 1'b1;
      tick();
      read_enb = 1'b0;
      checks++; if (empty !== 1'b1) $display("FAIL soft_write_dropped got empty=%b exp 1", empty); else passed++;
      checks++; if (data_out !== zz) $display("FAIL soft_read_ignored got %h exp zz", data_out); else passed++;
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 16; i++) wr_byte(1'b0, 8'h40 + 8'(i));
      checks++; if (full !== 1'b1) $display("FAIL async_prefull got %b exp 1", full); else passed++;
      #2;
      resetn = 1'b0;
      #1;
      checks++; if (empty !== 1'b1) $display("FAIL async_empty got %b exp 1", empty); else passed++;
      checks++; if (full !== 1'b0) $display("FAIL async_full got %b exp 0", full); else passed++;
      checks++; if (data_out !== 8'h00) $display("FAIL async_data got %h exp 00", data_out); else passed++;
      @(negedge clk);
      resetn = 1'b1;
   endtask

   initial begin
      zz = 'z;
      test_reset();
      test_fill();
      test_packet();
      test_back_to_back();
      test_soft_reset();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
